// File: rtl/level_pkg.sv
// level_pkg: shared types and defaults for the level tile loader.
package level_pkg;
  localparam int TILE_ADDR_W = 6;
  localparam int NUM_LEVELS = 4;
  typedef enum logic [1:0] {IDLE, WAIT_VS, READ, DONE} load_state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_INIT, REQ_NEXT, REQ_RESTART} req_sel_t;
  function automatic req_sel_t req_pick(input logic init, input logic next, input logic restart);
    return init ? REQ_INIT : next ? REQ_NEXT : restart ? REQ_RESTART : REQ_NONE;
  endfunction
endpackage

// File: rtl/level_load_ctrl_vs_edge_det.sv
// vs_edge_det: rising-edge detector on vs with a registered history bit.
module vs_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic vs,
  output logic rise
);
  logic vs_q;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) vs_q <= 1'b0;
    else vs_q <= vs;
  assign rise = vs & ~vs_q;
endmodule

// File: rtl/level_load_ctrl.sv
// level_load_ctrl: arbitrates level-change requests and streams a level's tiles from ROM to tile RAM.
// Define LEVEL_LOAD_VS_SYNC_EN to hold each load until a vs rising edge.
module level_load_ctrl #(
  parameter int ADDR_W = level_pkg::TILE_ADDR_W,
  parameter int NUM_LEVELS = level_pkg::NUM_LEVELS,
  parameter int LEVEL_W = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      vs,
  input  logic                      init_req,
  input  logic                      next_req,
  input  logic                      restart_req,
  output logic [LEVEL_W+ADDR_W-1:0] rom_addr,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [LEVEL_W-1:0]        level_idx,
  output logic                      busy,
  output logic                      done
);
  import level_pkg::*;
  load_state_t state, state_nxt;
  logic pend_init, pend_next, pend_restart;
  logic [ADDR_W-1:0] idx;
  logic vs_rise;
  req_sel_t sel;
  logic grant;
  assign sel = req_pick(pend_init, pend_next, pend_restart);
  assign grant = (state == IDLE) && (sel != REQ_NONE);
`ifdef LEVEL_LOAD_VS_SYNC_EN
  localparam load_state_t AFTER_GRANT = WAIT_VS;
  vs_edge_det u_vs_edge (.Clk(Clk), .Reset(Reset), .vs(vs), .rise(vs_rise));
`else
  localparam load_state_t AFTER_GRANT = READ;
  logic unused_vs;
  assign unused_vs = vs;
  assign vs_rise = 1'b0;
`endif
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = grant ? AFTER_GRANT : IDLE;
      WAIT_VS: state_nxt = vs_rise ? READ : WAIT_VS;
      READ:    state_nxt = (idx == '1) ? DONE : READ;
      DONE:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    rom_addr = {level_idx, idx};
  end
  // A pulse landing in the grant cycle survives the clear and is serviced by a later load.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      pend_init <= 1'b0;
      pend_next <= 1'b0;
      pend_restart <= 1'b0;
      level_idx <= '0;
      idx <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
    end else begin
      pend_init <= (grant ? 1'b0 : pend_init) | init_req;
      pend_next <= (grant ? 1'b0 : pend_next) | next_req;
      pend_restart <= (grant ? 1'b0 : pend_restart) | restart_req;
      level_idx <= !grant ? level_idx :
                   sel == REQ_INIT ? '0 :
                   sel == REQ_NEXT ? (level_idx == LEVEL_W'(NUM_LEVELS - 1) ? '0 : level_idx + LEVEL_W'(1)) :
                   level_idx;
      idx <= (state == READ) ? idx + ADDR_W'(1) : '0;
      wr_en <= state == READ;
      wr_addr <= (state == READ) ? idx : wr_addr;
    end
endmodule

// File: tb/tb_level_load_ctrl.sv
// tb_level_load_ctrl: table-driven loads with a write scoreboard plus multi-cycle corner sequences.
module tb_level_load_ctrl;
`ifdef LEVEL_LOAD_VS_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 0;
`endif
  logic Clk = 1'b0, Reset = 1'b1, vs = 1'b0;
  logic init_req = 1'b0, next_req = 1'b0, restart_req = 1'b0;
  logic [7:0] rom_addr;
  logic wr_en, busy, done;
  logic [5:0] wr_addr;
  logic [1:0] level_idx;
  int tests = 0, failed = 0;
  logic [7:0] sb[$];
  logic [7:0] prev_rom = '0;

  level_load_ctrl dut (
    .Clk(Clk), .Reset(Reset), .vs(vs), .init_req(init_req), .next_req(next_req),
    .restart_req(restart_req), .rom_addr(rom_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .level_idx(level_idx), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_load(input logic [1:0] lvl);
    for (int a = 0; a < 64; a++) sb.push_back({lvl, 6'(a)});
  endtask

  // Every write must match the head of the scoreboard; rom_addr is checked one cycle earlier.
  always @(negedge Clk) begin
    if (!Reset && wr_en) begin
      if (sb.size() == 0) check("unexpected_wr", {1'b1, wr_addr}, 32'h0);
      else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("wr_addr", wr_addr, e[5:0]);
        check("rom_addr", prev_rom, e);
      end
    end
    if (!Reset && done) check("done_last_wr", {wr_en, wr_addr}, {1'b1, 6'h3f});
    prev_rom = rom_addr;
  end

  task automatic run_load(input logic i, input logic n, input logic r, input logic [1:0] lvl);
    int k, first;
    first = -1;
    push_load(lvl);
    init_req = i; next_req = n; restart_req = r;
    @(negedge Clk);
    init_req = 0; next_req = 0; restart_req = 0;
    k = 1;
    while (!done && k < 300) begin
      vs = (k == 4);
      if (wr_en && first < 0) first = k;
      @(negedge Clk);
      k++;
    end
    vs = 0;
    check("first_wr_lat", first, 3 + LAT);
    check("done_lat", k, 66 + LAT);
    check("level_idx", level_idx, lvl);
    @(negedge Clk);
    check("idle_busy", busy, 0);
    check("sb_empty", sb.size(), 0);
    repeat (2) @(negedge Clk);
    check("no_extra_load", busy, 0);
  endtask

  typedef struct {
    logic i, n, r;
    logic [1:0] lvl;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int k, d1, d2, dn;
    vecs[0] = '{1, 0, 0, 2'd0};
    vecs[1] = '{0, 1, 0, 2'd1};
    vecs[2] = '{0, 1, 0, 2'd2};
    vecs[3] = '{0, 0, 1, 2'd2};
    vecs[4] = '{1, 1, 0, 2'd0};
    vecs[5] = '{0, 1, 0, 2'd1};
    vecs[6] = '{0, 1, 0, 2'd2};
    vecs[7] = '{0, 1, 0, 2'd3};
    vecs[8] = '{0, 1, 0, 2'd0};
    vecs[9] = '{0, 1, 0, 2'd1};
    repeat (2) @(negedge Clk);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_level", level_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    Reset = 0;
    @(negedge Clk);
    foreach (vecs[v]) run_load(vecs[v].i, vecs[v].n, vecs[v].r, vecs[v].lvl);

    // restart during READ: second load follows done after just the IDLE cycle
    push_load(2'd2);
    next_req = 1;
    @(negedge Clk);
    next_req = 0;
    k = 1; d1 = -1; d2 = -1;
    while (d2 < 0 && k < 400) begin
      vs = (k == 4) || (d1 >= 0 && k == d1 + 4);
      if (k == 20) begin restart_req = 1; push_load(2'd2); end
      else restart_req = 0;
      if (done) begin if (d1 < 0) d1 = k; else d2 = k; end
      @(negedge Clk);
      k++;
    end
    vs = 0;
    check("restart_done1", d1, 66 + LAT);
    check("restart_done2", d2, 132 + 2 * LAT);
    check("restart_level", level_idx, 2);
    @(negedge Clk);
    check("restart_sb_empty", sb.size(), 0);

    // reset mid-load at wr_addr 20
    push_load(2'd3);
    next_req = 1;
    @(negedge Clk);
    next_req = 0;
    k = 1;
    while (!(wr_en && wr_addr == 6'd20) && k < 300) begin
      vs = (k == 4);
      @(negedge Clk);
      k++;
    end
    vs = 0;
    check("reached_wr20", {wr_en, wr_addr}, {1'b1, 6'd20});
    Reset = 1;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_level", level_idx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    sb.delete();
    repeat (2) @(negedge Clk);
    Reset = 0;
    dn = 0;
    repeat (80) begin
      @(negedge Clk);
      if (done || wr_en) dn++;
    end
    check("midrst_no_activity", dn, 0);

`ifdef LEVEL_LOAD_VS_SYNC_EN
    // vs already high at request: must wait for a fresh rising edge
    vs = 1;
    repeat (3) @(negedge Clk);
    push_load(2'd0);
    init_req = 1;
    @(negedge Clk);
    init_req = 0;
    repeat (10) @(negedge Clk);
    check("vs_high_waits_busy", busy, 1);
    check("vs_high_no_wr", wr_en, 0);
    vs = 0;
    repeat (2) @(negedge Clk);
    vs = 1;
    k = 0; d1 = -1;
    while (!done && k < 300) begin
      @(negedge Clk);
      k++;
      if (wr_en && d1 < 0) d1 = k;
    end
    vs = 0;
    check("vs_first_wr", d1, 2);
    check("vs_done", k, 65);
    @(negedge Clk);
    check("vs_sb_empty", sb.size(), 0);
`else
    // vs is ignored: held high throughout, load timing unchanged
    vs = 1;
    push_load(2'd1);
    next_req = 1;
    @(negedge Clk);
    next_req = 0;
    k = 1; d1 = -1;
    while (!done && k < 300) begin
      if (wr_en && d1 < 0) d1 = k;
      @(negedge Clk);
      k++;
    end
    vs = 0;
    check("novs_first_wr", d1, 3);
    check("novs_done", k, 66);
    check("novs_level", level_idx, 1);
    @(negedge Clk);
    check("novs_sb_empty", sb.size(), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
